mem_access_wb: RTL and testbench
================================

Name: mem_access_wb

Overview:
- MEM stage plus MEM/WB pipeline register, directly downstream of the EX/MEM register.
- Takes EX/MEM control and data, performs the data-memory access over a req/ack handshake with variable latency, and registers the write-back fields.
- Asserts stall_o so that EX/MEM and the upstream stages hold while an access is outstanding.

Parameters:
- DATA_W, 32, data and address width.
- REG_W, 5, register-index width.
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit (used only with the optional feature).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- MemtoReg_i  in  1  WB select from EX/MEM.
- RegWrite_i  in  1  register-file write enable from EX/MEM.
- MemWrite_i  in  1  store request.
- MemRead_i  in  1  load request.
- ALU_result_i  in  DATA_W  address or ALU result.
- Mem_Write_Data_i  in  DATA_W  store data.
- Write_register_i  in  REG_W  destination register.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1=write, 0=read.
- mem_addr_o  out  DATA_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  read data, valid when mem_ack_i=1.
- mem_ack_i  in  1  access complete; sampled on the same cycle as req.
- stall_o  out  1  hold upstream stages.
- MemtoReg_o  out  1  registered WB select.
- RegWrite_o  out  1  registered write enable.
- Read_data_o  out  DATA_W  registered load data.
- ALU_result_o  out  DATA_W  registered ALU result.
- Write_register_o  out  REG_W  registered destination register.
- err_o  out  1  timeout error flag, sticky.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE; hold registers cleared.
  - All registered outputs 0; err_o=0.
  - mem_req_o=0 and stall_o=0 while reset is asserted.
- Access condition: acc = MemRead_i | MemWrite_i.
- Both read and write asserted: treated as a write; mem_we_o=1 and Read_data_o captures 0.
- State IDLE:
  - mem_req_o=acc.
  - mem_we_o, mem_addr_o and mem_wdata_o are driven combinationally from MemWrite_i, ALU_result_i and Mem_Write_Data_i.
  - No acc: WB register captures the inputs at the posedge; Read_data_o<=0; stall_o=0.
  - acc with mem_ack_i=1 (zero-wait): WB captures the inputs; Read_data_o<=mem_rdata_i for a read, 0 for a write; stall_o=0; stay in IDLE.
  - acc with mem_ack_i=0: stall_o=1; latch all inputs into hold registers; WB captures a bubble (RegWrite_o=0, MemtoReg_o=0, other outputs 0); next state WAIT.
- State WAIT:
  - mem_req_o=1; mem_we_o, mem_addr_o and mem_wdata_o are driven from the hold registers and stay stable until ack.
  - stall_o=~mem_ack_i.
  - mem_ack_i=0: WB captures a bubble; stay in WAIT.
  - mem_ack_i=1: WB captures the hold registers plus rdata (rdata for reads only); next state IDLE. Upstream advances on the same edge, so no access is re-issued.
- Latency:
  - Each instruction reaches the WB outputs one clock after its ack, or after its entry for non-memory instructions.
  - A memory access costs N extra stall cycles, where N = cycles before ack.
- Ack handling:
  - mem_ack_i while mem_req_o=0 is ignored.
  - Upstream inputs are not sampled in WAIT.
- Reset mid-WAIT: request dropped immediately; the pending access is abandoned and its WB is lost.
- Write-back is purely registered; there is no combinational path from mem_rdata_i to the WB outputs.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on WAIT entry and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 with no ack, the next state is IDLE and stall_o=0 on that cycle.
  - WB captures the instruction with RegWrite_o forced to 0.
  - err_o is set and stays set until reset.
  - An ack on the timeout cycle takes priority: normal completion, no error.
- Undefined: no counter; WAIT persists indefinitely; err_o is tied to 0.

Test Plan:
- Reset then ALU op (RegWrite_i=1, ALU_result_i=0x0000_00A5, Write_register_i=3, no mem) -> next cycle RegWrite_o=1, ALU_result_o=0xA5, Write_register_o=3, Read_data_o=0, stall_o never 1.
- Load at 0x10, mem_ack_i raised 3 cycles after req, rdata=0xDEAD_BEEF -> stall_o=1 for exactly 3 cycles, mem_addr_o=0x10 stable, 3 bubble cycles with RegWrite_o=0, then Read_data_o=0xDEADBEEF, MemtoReg_o=1.
- Zero-wait store (addr 0x20, data 0x1234, ack in same cycle) -> mem_we_o=1, no stall, next-cycle RegWrite_o=0, Read_data_o=0.
- Back-to-back load/load, each acked after 1 wait cycle -> each stalls exactly 1 cycle, two correct write-backs in order, no duplicated request.
- rst_i low during WAIT -> mem_req_o=0 immediately, all outputs 0; after release the next instruction proceeds normally.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> stall released after 4 WAIT cycles, RegWrite_o=0, err_o=1 held until reset.

Source files
------------

// File: rtl/mem_access_wb.sv
// mem_access_wb: MEM stage plus MEM/WB pipeline register.
//
// Performs the data-memory access for the instruction held in EX/MEM over a
// req/ack handshake with variable latency, then registers the write-back
// fields. While an access is outstanding stall_o holds EX/MEM and upstream.
//
// Optional feature (macro MEM_TIMEOUT_EN): WAIT-state timeout. After
// TIMEOUT_CYCLES WAIT cycles without ack the access is abandoned, the
// instruction retires with RegWrite_o forced low and the sticky err_o is set.
// With the macro undefined WAIT persists until ack and err_o is tied to 0.
//
// Ports:
//   clk_i, rst_i (async, active low)
//   EX/MEM inputs : MemtoReg_i, RegWrite_i, MemWrite_i, MemRead_i,
//                   ALU_result_i, Mem_Write_Data_i, Write_register_i
//   Memory bus    : mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
//                   mem_rdata_i, mem_ack_i
//   Control       : stall_o, err_o
//   MEM/WB outputs: MemtoReg_o, RegWrite_o, Read_data_o, ALU_result_o,
//                   Write_register_o
module mem_access_wb #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned REG_W          = 5,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemtoReg_i,
    input  logic              RegWrite_i,
    input  logic              MemWrite_i,
    input  logic              MemRead_i,
    input  logic [DATA_W-1:0] ALU_result_i,
    input  logic [DATA_W-1:0] Mem_Write_Data_i,
    input  logic [REG_W-1:0]  Write_register_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              MemtoReg_o,
    output logic              RegWrite_o,
    output logic [DATA_W-1:0] Read_data_o,
    output logic [DATA_W-1:0] ALU_result_o,
    output logic [REG_W-1:0]  Write_register_o,
    output logic              err_o
);

    typedef enum logic [0:0] {StIdle, StWait} state_t;

    state_t            state_q;
    logic              hold_memtoreg;
    logic              hold_regwrite;
    logic              hold_memwrite;
    logic              hold_memread;
    logic [DATA_W-1:0] hold_alu;
    logic [DATA_W-1:0] hold_wdata;
    logic [REG_W-1:0]  hold_wreg;

    logic acc;
    logic in_wait;
    logic timeout_hit;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

`ifdef MEM_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       err_q;

    assign timeout_hit = in_wait & ~mem_ack_i & (to_cnt == TO_LAST);
    assign err_o       = err_q;
`else
    logic unused_to_last;

    assign unused_to_last = ^TO_LAST;
    assign timeout_hit    = 1'b0;
    assign err_o          = 1'b0;
`endif

    always_comb begin
        acc         = MemRead_i | MemWrite_i;
        in_wait     = (state_q == StWait);
        // Request and stall are forced low while reset is asserted, even if
        // EX/MEM presents a memory instruction.
        mem_req_o   = rst_i & (in_wait | acc);
        mem_we_o    = in_wait ? hold_memwrite : MemWrite_i;
        mem_addr_o  = in_wait ? hold_alu      : ALU_result_i;
        mem_wdata_o = in_wait ? hold_wdata    : Mem_Write_Data_i;
        // A timeout releases the stall on its own cycle so upstream advances.
        stall_o     = rst_i & (in_wait ? (~mem_ack_i & ~timeout_hit)
                                       : (acc & ~mem_ack_i));
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q          <= StIdle;
            hold_memtoreg    <= 1'b0;
            hold_regwrite    <= 1'b0;
            hold_memwrite    <= 1'b0;
            hold_memread     <= 1'b0;
            hold_alu         <= '0;
            hold_wdata       <= '0;
            hold_wreg        <= '0;
            MemtoReg_o       <= 1'b0;
            RegWrite_o       <= 1'b0;
            Read_data_o      <= '0;
            ALU_result_o     <= '0;
            Write_register_o <= '0;
`ifdef MEM_TIMEOUT_EN
            to_cnt           <= '0;
            err_q            <= 1'b0;
`endif
        end else begin
            // Default: WB captures a bubble; overridden when an instruction retires.
            MemtoReg_o       <= 1'b0;
            RegWrite_o       <= 1'b0;
            Read_data_o      <= '0;
            ALU_result_o     <= '0;
            Write_register_o <= '0;
            unique case (state_q)
                StIdle: begin
                    if (acc && !mem_ack_i) begin
                        hold_memtoreg <= MemtoReg_i;
                        hold_regwrite <= RegWrite_i;
                        hold_memwrite <= MemWrite_i;
                        hold_memread  <= MemRead_i;
                        hold_alu      <= ALU_result_i;
                        hold_wdata    <= Mem_Write_Data_i;
                        hold_wreg     <= Write_register_i;
                        state_q       <= StWait;
`ifdef MEM_TIMEOUT_EN
                        to_cnt        <= '0;
`endif
                    end else begin
                        MemtoReg_o       <= MemtoReg_i;
                        RegWrite_o       <= RegWrite_i;
                        ALU_result_o     <= ALU_result_i;
                        Write_register_o <= Write_register_i;
                        // Read+write together is a write: no load data.
                        Read_data_o      <= (MemRead_i && !MemWrite_i) ? mem_rdata_i : '0;
                    end
                end
                StWait: begin
                    if (mem_ack_i) begin
                        MemtoReg_o       <= hold_memtoreg;
                        RegWrite_o       <= hold_regwrite;
                        ALU_result_o     <= hold_alu;
                        Write_register_o <= hold_wreg;
                        Read_data_o      <= (hold_memread && !hold_memwrite) ? mem_rdata_i : '0;
                        state_q          <= StIdle;
                    end else if (timeout_hit) begin
`ifdef MEM_TIMEOUT_EN
                        MemtoReg_o       <= hold_memtoreg;
                        ALU_result_o     <= hold_alu;
                        Write_register_o <= hold_wreg;
                        err_q            <= 1'b1;
`endif
                        state_q          <= StIdle;
                    end else begin
`ifdef MEM_TIMEOUT_EN
                        to_cnt           <= to_cnt + 8'd1;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_wb.sv
// Self-checking bench for mem_access_wb: table of single-cycle transactions
// followed by hand-written multi-cycle sequences (wait states, back-to-back
// loads, reset during WAIT, optional timeout).
module tb_mem_access_wb;

    logic        clk;
    logic        rst;
    logic        m2r_i, rw_i, mw_i, mr_i;
    logic [31:0] alu_i, wd_i;
    logic [4:0]  wr_i;
    logic        req, we;
    logic [31:0] addr, wdata, rdata;
    logic        ack;
    logic        stall;
    logic        m2r_o, rw_o;
    logic [31:0] rd_o, alu_o;
    logic [4:0]  wr_o;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_wb #(
        .DATA_W        (32),
        .REG_W         (5),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .MemtoReg_i      (m2r_i),
        .RegWrite_i      (rw_i),
        .MemWrite_i      (mw_i),
        .MemRead_i       (mr_i),
        .ALU_result_i    (alu_i),
        .Mem_Write_Data_i(wd_i),
        .Write_register_i(wr_i),
        .mem_req_o       (req),
        .mem_we_o        (we),
        .mem_addr_o      (addr),
        .mem_wdata_o     (wdata),
        .mem_rdata_i     (rdata),
        .mem_ack_i       (ack),
        .stall_o         (stall),
        .MemtoReg_o      (m2r_o),
        .RegWrite_o      (rw_o),
        .Read_data_o     (rd_o),
        .ALU_result_o    (alu_o),
        .Write_register_o(wr_o),
        .err_o           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        m2r, rw, mw, mr;
        logic [31:0] alu, wd;
        logic [4:0]  wr;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req, e_we, e_stall;
        logic        e_m2r, e_rw;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic m2r, input logic rw, input logic mw, input logic mr,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
        m2r_i = m2r; rw_i = rw; mw_i = mw; mr_i = mr;
        alu_i = a; wd_i = d; wr_i = r;
    endtask

    task automatic nop();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        ack = 1'b0; rdata = 32'h0;
    endtask

    initial begin
        // m2r rw mw mr alu wd wr ack rdata | req we stall | m2r_o rw_o rd_o
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_00A5, 32'h0, 5'd3, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h1234, 5'd4, 1'b1, 32'hFFFF,
                    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 5'd7, 1'b1, 32'hCAFE_F00D,
                    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0060, 32'h5A5A, 5'd8, 1'b1, 32'h55,
                    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0070, 32'h0, 5'd9, 1'b1, 32'h77,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};

        // Reset with a load presented: request and stall must stay low.
        rst = 1'b1;
        nop();
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd1);
        #2 rst = 1'b0;
        #1;
        chk("reset_req", {31'h0, req}, 32'h0);
        chk("reset_stall", {31'h0, stall}, 32'h0);
        tick();
        tick();
        chk("reset_rw", {31'h0, rw_o}, 32'h0);
        chk("reset_m2r", {31'h0, m2r_o}, 32'h0);
        chk("reset_rd", rd_o, 32'h0);
        chk("reset_alu", alu_o, 32'h0);
        chk("reset_wr", {27'h0, wr_o}, 32'h0);
        chk("reset_err", {31'h0, err}, 32'h0);
        nop();
        rst = 1'b1;
        tick();

        // Single-cycle transactions from the table.
        for (int i = 0; i < 5; i++) begin
            set_in(vecs[i].m2r, vecs[i].rw, vecs[i].mw, vecs[i].mr,
                   vecs[i].alu, vecs[i].wd, vecs[i].wr);
            ack = vecs[i].ack;
            rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_req", i), {31'h0, req}, {31'h0, vecs[i].e_req});
            chk($sformatf("v%0d_stall", i), {31'h0, stall}, {31'h0, vecs[i].e_stall});
            chk($sformatf("v%0d_addr", i), addr, vecs[i].alu);
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d_we", i), {31'h0, we}, {31'h0, vecs[i].e_we});
                chk($sformatf("v%0d_wdata", i), wdata, vecs[i].wd);
            end
            tick();
            chk($sformatf("v%0d_m2r_o", i), {31'h0, m2r_o}, {31'h0, vecs[i].e_m2r});
            chk($sformatf("v%0d_rw_o", i), {31'h0, rw_o}, {31'h0, vecs[i].e_rw});
            chk($sformatf("v%0d_rd_o", i), rd_o, vecs[i].e_rd);
            chk($sformatf("v%0d_alu_o", i), alu_o, vecs[i].alu);
            chk($sformatf("v%0d_wr_o", i), {27'h0, wr_o}, {27'h0, vecs[i].wr});
        end
        nop();
        tick();

        // Load at 0x10, ack three cycles after the request.
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd9);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) alu_i = 32'h0000_BAD0;
            ack = (k == 3);
            rdata = (k == 3) ? 32'hDEAD_BEEF : 32'h0;
            #1;
            chk($sformatf("ld3_stall_%0d", k), {31'h0, stall}, (k < 3) ? 32'h1 : 32'h0);
            chk($sformatf("ld3_req_%0d", k), {31'h0, req}, 32'h1);
            chk($sformatf("ld3_addr_%0d", k), addr, 32'h10);
            chk($sformatf("ld3_we_%0d", k), {31'h0, we}, 32'h0);
            if (k > 0) chk($sformatf("ld3_bubble_%0d", k), {31'h0, rw_o}, 32'h0);
            tick();
        end
        chk("ld3_rd", rd_o, 32'hDEAD_BEEF);
        chk("ld3_m2r", {31'h0, m2r_o}, 32'h1);
        chk("ld3_rw", {31'h0, rw_o}, 32'h1);
        chk("ld3_wr", {27'h0, wr_o}, 32'd9);
        chk("ld3_alu", alu_o, 32'h10);

        // Back-to-back loads, each acked after one wait cycle.
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 5'd1);
        ack = 1'b0;
        #1;
        chk("b2b1_stall_a", {31'h0, stall}, 32'h1);
        tick();
        ack = 1'b1; rdata = 32'h1111;
        #1;
        chk("b2b1_stall_b", {31'h0, stall}, 32'h0);
        chk("b2b1_addr", addr, 32'h100);
        tick();
        chk("b2b1_rd", rd_o, 32'h1111);
        chk("b2b1_wr", {27'h0, wr_o}, 32'd1);
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 5'd2);
        ack = 1'b0; rdata = 32'h0;
        #1;
        chk("b2b2_stall_a", {31'h0, stall}, 32'h1);
        chk("b2b2_addr", addr, 32'h200);
        tick();
        chk("b2b2_bubble", {31'h0, rw_o}, 32'h0);
        ack = 1'b1; rdata = 32'h2222;
        #1;
        chk("b2b2_stall_b", {31'h0, stall}, 32'h0);
        tick();
        chk("b2b2_rd", rd_o, 32'h2222);
        chk("b2b2_wr", {27'h0, wr_o}, 32'd2);
        nop();
        #1;
        chk("b2b_no_dup_req", {31'h0, req}, 32'h0);
        tick();

        // Reset while in WAIT: request dropped, access abandoned.
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 5'd3);
        tick();
        rst = 1'b0;
        #1;
        chk("rstw_req", {31'h0, req}, 32'h0);
        chk("rstw_stall", {31'h0, stall}, 32'h0);
        chk("rstw_rw", {31'h0, rw_o}, 32'h0);
        chk("rstw_rd", rd_o, 32'h0);
        tick();
        rst = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h44, 32'h0, 5'd5);
        ack = 1'b1; rdata = 32'h0000_ABCD;
        #1;
        chk("rstw_after_req", {31'h0, req}, 32'h1);
        chk("rstw_after_addr", addr, 32'h44);
        chk("rstw_after_stall", {31'h0, stall}, 32'h0);
        tick();
        chk("rstw_after_rd", rd_o, 32'h0000_ABCD);
        chk("rstw_after_wr", {27'h0, wr_o}, 32'd5);
        chk("rstw_after_rw", {31'h0, rw_o}, 32'h1);
        nop();
        tick();

`ifdef MEM_TIMEOUT_EN
        // Timeout after 4 WAIT cycles without ack.
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h50, 32'h0, 5'd6);
        #1;
        chk("to_stall_idle", {31'h0, stall}, 32'h1);
        tick();
        for (int w = 1; w <= 4; w++) begin
            #1;
            chk($sformatf("to_stall_w%0d", w), {31'h0, stall}, (w < 4) ? 32'h1 : 32'h0);
            chk($sformatf("to_err_w%0d", w), {31'h0, err}, 32'h0);
            tick();
        end
        nop();
        #1;
        chk("to_rw", {31'h0, rw_o}, 32'h0);
        chk("to_wr", {27'h0, wr_o}, 32'd6);
        chk("to_err", {31'h0, err}, 32'h1);
        chk("to_req_after", {31'h0, req}, 32'h0);
        tick();
        tick();
        chk("to_err_sticky", {31'h0, err}, 32'h1);
        rst = 1'b0;
        #1;
        chk("to_err_cleared", {31'h0, err}, 32'h0);
        tick();
        rst = 1'b1;
        tick();
`else
        chk("err_tied_low", {31'h0, err}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
